// File: rtl/ifetch_2432_pkg.sv
// Shared constants and types for the ifetch_2432 instruction prefetch stage.
// The default widths match the cpu_2432 core's address and instruction buses.
package ifetch_2432_pkg;

  localparam int IFETCH_DEPTH = 4;
  localparam int IFETCH_AW    = 24;
  localparam int IFETCH_IW    = 24;

  // How the core PC relates to the queued window this cycle.
  typedef enum logic [1:0] {
    LK_HIT   = 2'd0,
    LK_DRAIN = 2'd1,
    LK_REDIR = 2'd2
  } lookup_e;

endpackage

// File: rtl/ifetch_2432.sv
// Prefetch queue between cpu_2432 and a variable-latency instruction memory.
// The core is clock-enabled only when its PC is present in the queue; non-sequential PCs flush and refetch.
module ifetch_2432
  import ifetch_2432_pkg::*;
#(
  parameter int DEPTH = IFETCH_DEPTH,
  parameter int AW    = IFETCH_AW,
  parameter int IW    = IFETCH_IW
) (
  input  logic          i_clk,
  input  logic          i_rstb,
  input  logic          i_clk_en,
  input  logic [AW-1:0] i_core_iaddr,
  output logic [IW-1:0] o_core_instr,
  output logic          o_core_clk_en,
  output logic          o_mem_req,
  output logic [AW-1:0] o_mem_addr,
  input  logic          i_mem_ack,
  input  logic [IW-1:0] i_mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0] mem_q [DEPTH];

  logic [AW-1:0] expect_q, expect_d;
  logic [AW-1:0] fetch_q,  fetch_d;
  logic [AW-1:0] addr_q,   addr_d;
  logic [PW-1:0] rd_q,     rd_d;
  logic [PW-1:0] wr_q,     wr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          pend_q,   pend_d;
  logic          drop_q,   drop_d;

  logic [AW-1:0] off;
  logic [AW-1:0] count_ext;
  logic [PW-1:0] rd_idx;
  lookup_e       lk;
  logic          push;

  assign off       = i_core_iaddr - expect_q;
  assign count_ext = {{(AW-CW){1'b0}}, count_q};
  assign rd_idx    = rd_q + off[PW-1:0];

  // A backward target wraps to a huge unsigned offset and lands in LK_REDIR.
  always_comb begin
    lk = LK_REDIR;
    if (off < count_ext)       lk = LK_HIT;
    else if (off == count_ext) lk = LK_DRAIN;
  end

  assign o_core_instr  = (lk == LK_HIT) ? mem_q[rd_idx] : '0;
  assign o_core_clk_en = i_clk_en & (lk == LK_HIT);
  assign o_mem_req     = pend_q;
  assign o_mem_addr    = addr_q;

  always_comb begin
    expect_d = expect_q;
    fetch_d  = fetch_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    count_d  = count_q;
    pend_d   = pend_q & ~i_mem_ack;
    drop_d   = drop_q;
    push     = 1'b0;

    if (pend_q && i_mem_ack && drop_q) drop_d = 1'b0;

    if (lk == LK_REDIR) begin
      count_d  = '0;
      rd_d     = wr_q;
      expect_d = i_core_iaddr;
      fetch_d  = i_core_iaddr;
      if (pend_q && !i_mem_ack) drop_d = 1'b1;
    end else begin
      rd_d     = rd_q + off[PW-1:0];
      count_d  = count_q - off[CW-1:0];
      expect_d = i_core_iaddr;
      push     = pend_q & i_mem_ack & ~drop_q;
    end

    if (push) begin
      wr_d    = wr_q + PW'(1);
      count_d = count_d + CW'(1);
    end

    // Issue on the same edge an ack frees the slot, so zero-wait memory streams.
    if (!pend_d && (count_d < CW'(DEPTH))) begin
      pend_d  = 1'b1;
      addr_d  = fetch_d;
      fetch_d = fetch_d + AW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      expect_q <= '0;
      fetch_q  <= '0;
      addr_q   <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      expect_q <= expect_d;
      fetch_q  <= fetch_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_q] <= i_mem_rdata;
  end

endmodule

// File: doc/ifetch_2432.md
# ifetch_2432

Instruction prefetch stage that sits directly upstream of the `cpu_2432` core. It turns the core's combinational instruction address into handshaked reads from a variable-latency instruction memory. Fetched words are held in a small address-tagged queue, and the core's clock enable is gated so the core only advances when the instruction for its current PC is present. Taken jumps and branches are detected as non-sequential addresses; the queue is then flushed and fetch is redirected.

## Interface
Parameters:
- `DEPTH`, default 4: queue entries; power of two, at least 2.
- `AW`, default 24: instruction address width.
- `IW`, default 24: instruction word width.

Ports:
- `i_clk` in 1: clock.
- `i_rstb` in 1: reset. Asynchronous, active-low.
- `i_clk_en` in 1: global enable, as given to the core today.
- `i_core_iaddr` in AW: core PC (core `o_iaddr`).
- `o_core_instr` out IW: instruction for `i_core_iaddr` (core `i_instr`).
- `o_core_clk_en` out 1: core clock enable (core `i_clk_en`).
- `o_mem_req` out 1: memory read request, registered.
- `o_mem_addr` out AW: memory read address, registered.
- `i_mem_ack` in 1: request accepted; data valid this cycle.
- `i_mem_rdata` in IW: read data, qualified by `i_mem_ack`.

## Operation
State:
- `expect_q`: address of the head entry.
- `rd_q` / `wr_q`: queue pointers, log2(DEPTH) bits.
- `count_q`: 0..DEPTH.
- `fetch_q`: next address to fetch.
- `pend_q`: a request is outstanding.
- `drop_q`: discard the outstanding response.

Lookup, combinational:
- `off = i_core_iaddr - expect_q`, computed modulo 2^AW.
- hit = `off < count_q`.
- `o_core_instr` = entry[`rd_q + off`] on hit, else 0.
- `o_core_clk_en` = `i_clk_en & hit`.

Per-edge update. These occur every clock and are independent of `i_clk_en`, so the core's internal MCP stall needs no visibility here.
- Hit: retire `off` entries. `rd_q += off`, `count_q -= off`, `expect_q <= i_core_iaddr`. Only `off` of 0 or 1 occurs in practice; the design supports any value up to `DEPTH-1`.
- Drain (`off == count_q`): retire all entries, `expect_q <= i_core_iaddr`, no redirect. This is the sequential case where the needed word is in flight or is next to fetch.
- Redirect (`off > count_q`, including backward targets that wrap to a large unsigned offset):
  - `count_q <= 0`, `expect_q <= fetch_q <= i_core_iaddr`.
  - Set `drop_q` if `pend_q` is set and no ack occurs this cycle.
  - A redirect overrides any push in the same cycle.

Memory handshake:
- Issue a request when `!pend_q` and `count_q` (after retire/push) `< DEPTH`. This sets `o_mem_req`, loads `o_mem_addr <= fetch_q`, and increments `fetch_q` at issue.
- `o_mem_req` and `o_mem_addr` stay stable until the cycle of `i_mem_ack`. The request is never withdrawn on redirect; its data is discarded instead via `drop_q`.
- At most one request is outstanding. A new request may issue on the edge where the ack is seen, giving back-to-back one-cycle reads.
- Ack with `!drop_q`: push `i_mem_rdata` at `wr_q`, `count_q++`.
- Ack with `drop_q`: discard the data, clear `drop_q`.
- Full: no issue while `count_q + pend_q == DEPTH`.
- Simultaneous retire and push: `count_q` changes by `1 - off`. Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - `expect_q = fetch_q = 0`, matching core PC reset 0.
  - `count_q = 0`, `pend_q = drop_q = 0`.
  - `o_mem_req = 0`, `o_mem_addr = 0`.
  - `o_core_clk_en = 0` and `o_core_instr = 0` (empty queue, so no hit).
- Reset mid-transaction: the in-flight request is abandoned. Memory must tolerate `o_mem_req` dropping without an ack.
- Cold start or redirect, zero-wait memory:
  - Edge N: redirect registered.
  - Cycle N+1: `o_mem_req` high, ack.
  - Cycle N+2: hit, `o_core_clk_en` high.
  - Redirect penalty = 2 cycles + memory wait states.
- Streaming, zero-wait memory: one instruction per cycle sustained; `o_core_clk_en` stays high.
- `o_core_clk_en` has a combinational path from `i_core_iaddr`, which is a core register output, so there is no loop.

## Structure
- `DEPTH` default and the address/instruction widths go in `cpu_2432.vh` alongside the existing opcode defines.
- Single module. The queue storage is an inline register array; no sub-module is warranted.
- Integration: the top level replaces the direct instruction-memory connection with this block. The core's `i_clk_en` is driven from `o_core_clk_en`.

## Test plan
- Reset release, zero-wait memory returning `mem[a] = a ^ 24'h5A5A5A`, sequential PC: first `o_core_clk_en` two cycles after reset release; thereafter high every cycle with `o_core_instr == 24'h5A5A5A ^ pc`.
- Memory acks after 3 wait states on every request: core advances once per 4 cycles; `o_mem_addr` is stable while `o_mem_req` is high; `count_q` never exceeds 1.
- Core stalled (`i_core_iaddr` held at 5): queue fills to 4 entries (addresses 5..8), then `o_mem_req` stays low. On release, four hits follow back-to-back.
- Jump from PC 0x10 to 0x200 while a request for 0x13 is pending with 2 wait states: the 0x13 response is dropped; the next request is 0x200; first hit at 0x200 with the correct data.
- Backward branch from 0x40 to 0x3C (off wraps): redirect; `count_q` = 0; refetch from 0x3C.
- Reset asserted while `o_mem_req` is high: all outputs return to 0 asynchronously; fetch restarts at address 0.
